ipv4_tx_arb: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single IPv4 TX datapath between N_REQ transport requesters (UDP, ICMP, ...).

---
 rtl/ipv4_pkg.sv | 19 +
 rtl/ipv4_rr_pick.sv | 28 ++
 rtl/ipv4_tx_arb.sv | 122 ++++++++++++
 tb/tb_ipv4_tx_arb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_pkg.sv
// Shared IPv4 block definitions: field widths, protocol numbers, arbiter state.
package ipv4_pkg;

  localparam int PROT_W = 8;

  localparam logic [PROT_W-1:0] PROT_ICMP = 8'd1;
  localparam logic [PROT_W-1:0] PROT_UDP  = 8'd17;

  // Width of a valid-byte count for a stream of data_w bits (0..data_w/8).
  function automatic int len_w(input int data_w);
    return $clog2((data_w / 8) + 1);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ipv4_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above ptr, wrapping mod N.
module ipv4_rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any_v
);

  // Scan offsets from the far end down so the nearest requester to ptr is written last.
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    any_v = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[IW'(j)]) begin
        idx   = IW'(j);
        any_v = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipv4_tx_arb.sv
// Packet-granular round-robin arbiter in front of the IPv4 TX datapath.
// The owner is locked from arbitration until its last beat is accepted, it
// cancels, or the idle watchdog expires; its stream passes through combinationally.
module ipv4_tx_arb import ipv4_pkg::*; #(
  parameter  int N_REQ   = 2,
  parameter  int DATA_W  = 16,
  parameter  int TIMEOUT = 64,
  // entry i lives at bits [i*PROT_W +: PROT_W]; requester 0 is ICMP, 1 is UDP
  parameter  logic [N_REQ*PROT_W-1:0] PROT_TABLE = {PROT_UDP, PROT_ICMP},
  localparam int LEN_W   = len_w(DATA_W),
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int WD_W    = $clog2(TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        valid_i,
  input  logic [N_REQ-1:0]        start_i,
  input  logic [N_REQ-1:0]        last_i,
  input  logic [N_REQ-1:0]        cancel_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic [N_REQ*LEN_W-1:0]  len_i,
  output logic [N_REQ-1:0]        grant_o,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic                    start_o,
  output logic                    last_o,
  output logic                    cancel_o,
  output logic [DATA_W-1:0]       data_o,
  output logic [LEN_W-1:0]        len_o,
  output logic [PROT_W-1:0]       prot_o,
  output logic                    timeout_o
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, rr_q, pick, rr_nxt;
  logic [WD_W-1:0]   wd_q;
  logic              any_req, busy;
  logic              own_valid, own_start, own_last, own_cancel;
  logic [DATA_W-1:0] own_data;
  logic [LEN_W-1:0]  own_len;
  logic              raw_acc, wd_fire, kill, accept, rel_pkt;

  ipv4_rr_pick #(.N(N_REQ)) u_pick (
    .req   (req_i),
    .ptr   (rr_q),
    .idx   (pick),
    .any_v (any_req)
  );

  assign own_valid  = valid_i[owner_q];
  assign own_start  = start_i[owner_q];
  assign own_last   = last_i[owner_q];
  assign own_cancel = cancel_i[owner_q];
  assign own_data   = data_i[owner_q*DATA_W +: DATA_W];
  assign own_len    = len_i[owner_q*LEN_W +: LEN_W];
  assign rr_nxt     = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Output mux and kill logic; a cancel or watchdog expiry suppresses the beat.
  always_comb begin
    busy      = (state_q == BUSY);
    raw_acc   = busy & own_valid & ready_i & ~own_cancel;
    wd_fire   = busy & (wd_q == WD_W'(TIMEOUT - 1)) & ~raw_acc;
    kill      = busy & (own_cancel | wd_fire);
    valid_o   = busy & own_valid & ~kill;
    start_o   = busy & own_start;
    last_o    = busy & own_last;
    data_o    = busy ? own_data : '0;
    len_o     = busy ? own_len : '0;
    cancel_o  = kill;
    timeout_o = wd_fire;
    prot_o    = PROT_TABLE[owner_q*PROT_W +: PROT_W];
    grant_o   = '0;
    if (busy & ~kill) grant_o[owner_q] = ready_i;
    accept    = valid_o & ready_i;
    rel_pkt   = accept & last_o;
  end

  // Next-state: lock on any request, unlock on accepted last, cancel or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (kill | rel_pkt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Owner capture, round-robin pointer advance and idle watchdog.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      owner_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (any_req) owner_q <= pick;
        end
        BUSY: begin
          if (kill | rel_pkt) begin
            rr_q <= rr_nxt;
            wd_q <= '0;
          end else if (accept) begin
            wd_q <= '0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: wd_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_tx_arb.sv
// Scoreboard bench for ipv4_tx_arb: beats are queued as expected when driven
// and popped/compared whenever the arbiter hands a beat to IPv4 TX.
module tb_ipv4_tx_arb;
  import ipv4_pkg::*;

  localparam int N_REQ   = 2;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 2;
  localparam int TIMEOUT = 64;

  logic                    clk = 1'b0;
  logic                    nreset;
  logic [N_REQ-1:0]        req_i, valid_i, start_i, last_i, cancel_i, grant_o;
  logic [N_REQ*DATA_W-1:0] data_i;
  logic [N_REQ*LEN_W-1:0]  len_i;
  logic                    ready_i, valid_o, start_o, last_o, cancel_o, timeout_o;
  logic [DATA_W-1:0]       data_o;
  logic [LEN_W-1:0]        len_o;
  logic [PROT_W-1:0]       prot_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  ipv4_tx_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nreset(nreset), .req_i(req_i), .valid_i(valid_i), .start_i(start_i),
    .last_i(last_i), .cancel_i(cancel_i), .data_i(data_i), .len_i(len_i),
    .grant_o(grant_o), .ready_i(ready_i), .valid_o(valid_o), .start_o(start_o),
    .last_o(last_o), .cancel_o(cancel_o), .data_o(data_o), .len_o(len_o),
    .prot_o(prot_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] prot_of(input int r);
    return (r == 0) ? 8'd1 : 8'd17;
  endfunction

  function automatic logic [31:0] pk(input logic [15:0] d, input logic s, input logic l,
                                     input logic [1:0] ln, input logic [7:0] p);
    return {4'b0, p, ln, s, l, d};
  endfunction

  function automatic logic [31:0] outs_flat();
    return 32'({valid_o, start_o, last_o, cancel_o, timeout_o, grant_o, len_o, data_o});
  endfunction

  // Compare every beat handed to IPv4 TX against the head of the scoreboard.
  always @(negedge clk) begin
    if (nreset === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (sb_q.size() == 0) chk("sb_extra", 32'(valid_o), 32'd0);
      else chk("sb_beat", pk(data_o, start_o, last_o, len_o, prot_o), sb_q.pop_front());
    end
  end

  task automatic clear_inputs();
    req_i = '0; valid_i = '0; start_i = '0; last_i = '0; cancel_i = '0;
    data_i = '0; len_i = '0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one beat on requester r and wait (bounded) for it to be accepted.
  task automatic drive_beat(input int r, input logic [15:0] d, input logic s, input logic l,
                            input logic [1:0] ln, output int waits);
    valid_i[r] = 1'b1;
    start_i[r] = s;
    last_i[r]  = l;
    data_i[r*DATA_W +: DATA_W] = d;
    len_i[r*LEN_W +: LEN_W]    = ln;
    sb_q.push_back(pk(d, s, l, ln, prot_of(r)));
    waits = 0;
    forever begin
      @(negedge clk);
      if (valid_i[r] && grant_o[r]) begin
        chk("gnt_onehot", 32'(grant_o), 32'(1 << r));
        break;
      end
      if (waits == 100) begin
        chk("beat_wait", 32'(waits), 32'd0);
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int r, input int n, input logic [15:0] base,
                          input bit keep_req, output int w0);
    int w;
    w0 = 0;
    req_i[r] = 1'b1;
    for (int b = 0; b < n; b++) begin
      drive_beat(r, base + 16'(b), b == 0, b == n - 1, 2'((b == n - 1) ? 1 : 2), w);
      if (b == 0) begin
        w0 = w;
        if (!keep_req) req_i[r] = 1'b0;
      end
    end
    valid_i[r] = 1'b0; start_i[r] = 1'b0; last_i[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int w, fire_c, g;
    logic fire_cancel;
    logic [N_REQ-1:0] fire_gnt;

    nreset  = 1'b0;
    ready_i = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rst_outs", outs_flat(), 32'd0);
    chk("rst_prot", 32'(prot_o), 32'd1);
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;

    // 1: single 3-beat packet from requester 0
    req_i[0] = 1'b1;
    @(negedge clk);
    chk("t1_arb_gnt", 32'(grant_o), 32'd0);
    chk("t1_arb_vld", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    send_pkt(0, 3, 16'h1000, 1'b0, w);
    chk("t1_lat", 32'(w), 32'd0);
    @(negedge clk);
    chk("t1_idle", 32'({grant_o, valid_o}), 32'd0);
    @(posedge clk); #1;

    // 2: both request right after reset; 0 first, then 1, pointer back to 0
    do_reset();
    req_i[1] = 1'b1;
    send_pkt(0, 2, 16'h2000, 1'b0, w);
    send_pkt(1, 4, 16'h2100, 1'b0, w);
    chk("t2_rr", 32'(dut.rr_q), 32'd0);

    // 3: requester 0 re-requests immediately; pending 1 must win next
    req_i[1] = 1'b1;
    send_pkt(0, 2, 16'h3000, 1'b1, w);
    send_pkt(1, 2, 16'h3100, 1'b0, w);
    send_pkt(0, 2, 16'h3200, 1'b0, w);

    // 4: owner (1) cancels on its second beat; 0 served next
    req_i = 2'b11;
    drive_beat(1, 16'h4100, 1'b1, 1'b0, 2'd2, w);
    req_i[1] = 1'b0;
    valid_i[1] = 1'b1; start_i[1] = 1'b0; cancel_i[1] = 1'b1;
    data_i[1*DATA_W +: DATA_W] = 16'h4101;
    @(negedge clk);
    chk("t4_cancel", 32'(cancel_o), 32'd1);
    chk("t4_vld", 32'(valid_o), 32'd0);
    chk("t4_tmo", 32'(timeout_o), 32'd0);
    @(posedge clk); #1;
    valid_i[1] = 1'b0; cancel_i[1] = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'({grant_o, cancel_o}), 32'd0);
    @(posedge clk); #1;
    send_pkt(0, 2, 16'h4000, 1'b0, w);

    // 5: owner never presents a beat; watchdog fires on the 64th busy cycle
    req_i[0] = 1'b1;
    fire_c = -1; g = 0; fire_cancel = 1'b0; fire_gnt = '1;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (grant_o[0]) g++;
      if (timeout_o) begin
        fire_c = c; fire_cancel = cancel_o; fire_gnt = grant_o;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t5_cycle", 32'(fire_c), 32'd64);
    chk("t5_cancel", 32'(fire_cancel), 32'd1);
    chk("t5_gnt", 32'(fire_gnt), 32'd0);
    chk("t5_gnt_cycles", 32'(g), 32'd63);
    @(posedge clk); #1;
    req_i[0] = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'({grant_o, timeout_o, cancel_o}), 32'd0);
    @(posedge clk); #1;

    // 6: stall mid-packet, then asynchronous reset
    req_i[0] = 1'b1;
    drive_beat(0, 16'h6000, 1'b1, 1'b0, 2'd2, w);
    req_i[0] = 1'b0;
    start_i[0] = 1'b0;
    data_i[0 +: DATA_W] = 16'h6001;
    ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_hold", 32'(data_o), 32'h6001);
      chk("t6_vld", 32'(valid_o), 32'd1);
      chk("t6_gnt", 32'(grant_o), 32'd0);
      @(posedge clk); #1;
    end
    #2;
    nreset = 1'b0;
    #1;
    chk("t6_rst_outs", outs_flat(), 32'd0);
    chk("t6_rst_prot", 32'(prot_o), 32'd1);
    clear_inputs();
    ready_i = 1'b1;
    @(posedge clk); #1;
    nreset = 1'b1;
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
